// File: rtl/hazard_bypass_unit.sv
// ID-stage hazard detection and operand bypass control for the 5-stage pipeline.
// Tracks one outstanding MUL/DIV destination and counts stalled cycles.
module hazard_bypass_unit #(
   parameter int NUM_RD = 2,
   parameter int AW     = 5,
   parameter int CW     = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_RD-1:0]    rd_en,
   input  logic [NUM_RD*AW-1:0] rd_addr,
   input  logic                 id_wen,
   input  logic [AW-1:0]        id_waddr,
   input  logic                 exe_wen,
   input  logic [AW-1:0]        exe_waddr,
   input  logic                 exe_is_load,
   input  logic                 mem_wen,
   input  logic [AW-1:0]        mem_waddr,
   input  logic                 mem_is_load,
   input  logic                 wb_wen,
   input  logic [AW-1:0]        wb_waddr,
   input  logic                 md_start,
   input  logic                 md_done,
   input  logic                 flush,
   output logic [NUM_RD*3-1:0]  fwd_sel,
   output logic                 stall,
   output logic                 pc_write,
   output logic                 ir_write,
   output logic                 md_busy,
   output logic [CW-1:0]        stall_cnt
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam logic [2:0] FWD_RF  = 3'd0;
   localparam logic [2:0] FWD_EXE = 3'd1;
   localparam logic [2:0] FWD_MEM = 3'd2;
   localparam logic [2:0] FWD_WB  = 3'd3;
   localparam logic [2:0] FWD_MD  = 3'd4;

   state_t        state, state_nxt;
   logic [AW-1:0] pend_addr, pend_addr_nxt;
   logic          busy;
   logic          load_use, md_raw, md_waw, md_struct, start_ok;

   logic [NUM_RD-1:0] rd_valid, exe_hit, mem_hit, wb_hit, pend_match;

   assign busy = (state == BUSY);

   // NOTE: every signal written here gets a default first, so no path can leave
   // a value held over from a previous evaluation (which would infer a latch).
   always_comb begin
      rd_valid   = '0;
      exe_hit    = '0;
      mem_hit    = '0;
      wb_hit     = '0;
      pend_match = '0;
      fwd_sel    = '0;
      load_use   = 1'b0;
      md_raw     = 1'b0;
      for (int i = 0; i < NUM_RD; i++) begin
         rd_valid[i]   = rd_en[i] && (rd_addr[i*AW +: AW] != '0);
         exe_hit[i]    = rd_valid[i] && exe_wen && (rd_addr[i*AW +: AW] == exe_waddr);
         mem_hit[i]    = rd_valid[i] && mem_wen && (rd_addr[i*AW +: AW] == mem_waddr);
         wb_hit[i]     = rd_valid[i] && wb_wen  && (rd_addr[i*AW +: AW] == wb_waddr);
         pend_match[i] = rd_valid[i] && busy    && (rd_addr[i*AW +: AW] == pend_addr);

         if (exe_hit[i])                    fwd_sel[i*3 +: 3] = FWD_EXE;
         else if (mem_hit[i])               fwd_sel[i*3 +: 3] = FWD_MEM;
         else if (wb_hit[i])                fwd_sel[i*3 +: 3] = FWD_WB;
         else if (pend_match[i] && md_done) fwd_sel[i*3 +: 3] = FWD_MD;
         else                               fwd_sel[i*3 +: 3] = FWD_RF;

         // A load in MEM is only a hazard if a younger EXE write does not shadow it.
         load_use = load_use || (exe_hit[i] && exe_is_load)
                             || (mem_hit[i] && mem_is_load && !exe_hit[i]);
         md_raw   = md_raw || (pend_match[i] && !md_done);
      end
   end

   assign md_waw    = busy && !md_done && id_wen && (id_waddr != '0) && (id_waddr == pend_addr);
   assign md_struct = md_start && busy && !md_done;
   assign stall     = (load_use || md_raw || md_waw || md_struct) && !flush && !rst;
   assign pc_write  = !stall;
   assign ir_write  = !stall;
   assign md_busy   = busy;
   assign start_ok  = md_start && !stall && !flush;

   always_comb begin
      state_nxt     = state;
      pend_addr_nxt = pend_addr;
      if (flush) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start_ok) begin
                  state_nxt     = BUSY;
                  pend_addr_nxt = id_waddr;
               end
            end
            BUSY: begin
               if (md_done) begin
                  if (start_ok) pend_addr_nxt = id_waddr;
                  else          state_nxt     = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pend_addr <= '0;
         stall_cnt <= '0;
      end else begin
         state     <= state_nxt;
         pend_addr <= pend_addr_nxt;
         if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CW'(1);
      end
   end

endmodule

// File: tb/tb_hazard_bypass_unit.sv
// Directed bench for hazard_bypass_unit: forwarding priority, load-use, MUL/DIV
// scoreboard, flush and stall-counter saturation (second instance with CW=2).
module tb_hazard_bypass_unit;

   localparam int NUM_RD = 2;
   localparam int AW     = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic [NUM_RD-1:0] rd_en;
   logic [NUM_RD*AW-1:0] rd_addr;
   logic              id_wen, exe_wen, exe_is_load, mem_wen, mem_is_load, wb_wen;
   logic [AW-1:0]     id_waddr, exe_waddr, mem_waddr, wb_waddr;
   logic              md_start, md_done, flush;
   logic [NUM_RD*3-1:0] fwd_sel, fwd_sel_s;
   logic              stall, pc_write, ir_write, md_busy;
   logic              stall_s, pc_write_s, ir_write_s, md_busy_s;
   logic [31:0]       stall_cnt;
   logic [1:0]        stall_cnt_s;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   hazard_bypass_unit #(.NUM_RD(NUM_RD), .AW(AW), .CW(32)) dut (
      .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
      .id_wen(id_wen), .id_waddr(id_waddr),
      .exe_wen(exe_wen), .exe_waddr(exe_waddr), .exe_is_load(exe_is_load),
      .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_is_load(mem_is_load),
      .wb_wen(wb_wen), .wb_waddr(wb_waddr),
      .md_start(md_start), .md_done(md_done), .flush(flush),
      .fwd_sel(fwd_sel), .stall(stall), .pc_write(pc_write), .ir_write(ir_write),
      .md_busy(md_busy), .stall_cnt(stall_cnt)
   );

   hazard_bypass_unit #(.NUM_RD(NUM_RD), .AW(AW), .CW(2)) dut_sat (
      .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
      .id_wen(id_wen), .id_waddr(id_waddr),
      .exe_wen(exe_wen), .exe_waddr(exe_waddr), .exe_is_load(exe_is_load),
      .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_is_load(mem_is_load),
      .wb_wen(wb_wen), .wb_waddr(wb_waddr),
      .md_start(md_start), .md_done(md_done), .flush(flush),
      .fwd_sel(fwd_sel_s), .stall(stall_s), .pc_write(pc_write_s), .ir_write(ir_write_s),
      .md_busy(md_busy_s), .stall_cnt(stall_cnt_s)
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic clear_inputs();
      rd_en = '0; rd_addr = '0;
      id_wen = 1'b0; id_waddr = '0;
      exe_wen = 1'b0; exe_waddr = '0; exe_is_load = 1'b0;
      mem_wen = 1'b0; mem_waddr = '0; mem_is_load = 1'b0;
      wb_wen = 1'b0; wb_waddr = '0;
      md_start = 1'b0; md_done = 1'b0; flush = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset with every request active
      clear_inputs();
      rst = 1'b1;
      rd_en = 2'b11; rd_addr = {5'd7, 5'd7};
      id_wen = 1'b1; id_waddr = 5'd7;
      exe_wen = 1'b1; exe_waddr = 5'd7; exe_is_load = 1'b1;
      mem_wen = 1'b1; mem_waddr = 5'd7; mem_is_load = 1'b1;
      md_start = 1'b1;
      #1;
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_pc_write", 32'(pc_write), 32'd1);
      check("rst_ir_write", 32'(ir_write), 32'd1);
      tick();
      tick();
      rst = 1'b0;
      clear_inputs();
      #1;
      check("post_rst_busy", 32'(md_busy), 32'd0);
      check("post_rst_cnt", stall_cnt, 32'd0);
      check("post_rst_stall", 32'(stall), 32'd0);

      // ALU chain
      exe_wen = 1'b1; exe_waddr = 5'd5;
      rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
      #1;
      check("alu_exe_fwd", 32'(fwd_sel), 32'h01);
      check("alu_exe_stall", 32'(stall), 32'd0);
      exe_wen = 1'b0;
      mem_wen = 1'b1; mem_waddr = 5'd5;
      wb_wen = 1'b1; wb_waddr = 5'd5;
      #1;
      check("alu_mem_over_wb", 32'(fwd_sel), 32'h02);
      mem_wen = 1'b0;
      rd_en = 2'b10; rd_addr = {5'd5, 5'd0};
      #1;
      check("alu_wb_port1", 32'(fwd_sel), 32'h18);
      tick();

      // Load-use: EXE stall, MEM stall, then WB forward
      clear_inputs();
      exe_wen = 1'b1; exe_waddr = 5'd7; exe_is_load = 1'b1;
      rd_en = 2'b10; rd_addr = {5'd7, 5'd3};
      #1;
      check("lu_exe_stall", 32'(stall), 32'd1);
      check("lu_exe_pc_write", 32'(pc_write), 32'd0);
      tick();
      check("lu_cnt1", stall_cnt, 32'd1);
      exe_wen = 1'b0; exe_is_load = 1'b0;
      mem_wen = 1'b1; mem_waddr = 5'd7; mem_is_load = 1'b1;
      #1;
      check("lu_mem_stall", 32'(stall), 32'd1);
      tick();
      mem_wen = 1'b0; mem_is_load = 1'b0;
      wb_wen = 1'b1; wb_waddr = 5'd7;
      #1;
      check("lu_wb_fwd", 32'(fwd_sel), 32'h18);
      check("lu_wb_stall", 32'(stall), 32'd0);
      check("lu_cnt2", stall_cnt, 32'd2);
      check("lu_cnt2_sat", 32'(stall_cnt_s), 32'd2);
      tick();

      // Zero register and disabled port
      clear_inputs();
      exe_wen = 1'b1; exe_waddr = 5'd0; exe_is_load = 1'b1;
      rd_en = 2'b01; rd_addr = {5'd0, 5'd0};
      #1;
      check("r0_fwd", 32'(fwd_sel), 32'h00);
      check("r0_stall", 32'(stall), 32'd0);
      exe_waddr = 5'd5; exe_is_load = 1'b0;
      rd_en = 2'b00; rd_addr = {5'd5, 5'd5};
      #1;
      check("rden0_fwd", 32'(fwd_sel), 32'h00);
      tick();

      // Multi-cycle op on r9
      clear_inputs();
      md_start = 1'b1; id_wen = 1'b1; id_waddr = 5'd9;
      #1;
      check("md_start_stall", 32'(stall), 32'd0);
      tick();
      check("md_busy_rise", 32'(md_busy), 32'd1);
      clear_inputs();
      id_wen = 1'b1; id_waddr = 5'd9;
      #1;
      check("md_waw_stall", 32'(stall), 32'd1);
      clear_inputs();
      rd_en = 2'b01; rd_addr = {5'd0, 5'd9};
      #1;
      check("md_raw_stall1", 32'(stall), 32'd1);
      tick();
      check("md_raw_stall2", 32'(stall), 32'd1);
      tick();
      md_done = 1'b1;
      #1;
      check("md_done_fwd", 32'(fwd_sel), 32'h04);
      check("md_done_stall", 32'(stall), 32'd0);
      tick();
      md_done = 1'b0;
      #1;
      check("md_busy_fall", 32'(md_busy), 32'd0);
      check("md_cnt4", stall_cnt, 32'd4);
      check("md_cnt_sat", 32'(stall_cnt_s), 32'd3);

      // Structural stall then back-to-back start in the done cycle
      clear_inputs();
      md_start = 1'b1; id_wen = 1'b1; id_waddr = 5'd9;
      tick();
      id_waddr = 5'd10;
      #1;
      check("struct_stall", 32'(stall), 32'd1);
      tick();
      check("struct_busy", 32'(md_busy), 32'd1);
      md_done = 1'b1;
      #1;
      check("b2b_stall", 32'(stall), 32'd0);
      tick();
      clear_inputs();
      #1;
      check("b2b_busy", 32'(md_busy), 32'd1);
      rd_en = 2'b10; rd_addr = {5'd10, 5'd0};
      #1;
      check("b2b_pend_new", 32'(stall), 32'd1);
      rd_addr = {5'd9, 5'd0};
      #1;
      check("b2b_pend_old", 32'(stall), 32'd0);

      // Flush mid-op (pending r10); a start in the flush cycle is ignored
      rd_addr = {5'd10, 5'd0};
      flush = 1'b1; md_start = 1'b1; id_wen = 1'b1; id_waddr = 5'd11;
      #1;
      check("flush_stall", 32'(stall), 32'd0);
      tick();
      clear_inputs();
      #1;
      check("flush_busy", 32'(md_busy), 32'd0);
      rd_en = 2'b10; rd_addr = {5'd10, 5'd0};
      #1;
      check("flush_reader_stall", 32'(stall), 32'd0);
      check("flush_reader_fwd", 32'(fwd_sel), 32'h00);
      tick();
      check("final_cnt", stall_cnt, 32'd5);
      check("final_cnt_sat", 32'(stall_cnt_s), 32'd3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/hazard_bypass_unit.md
# hazard_bypass_unit

Parametrised ID-stage hazard and bypass controller for the 5-stage pipeline, successor to the two-port bypass unit. It generates per-port forwarding selects for NUM_RD register read ports from the EXE, MEM and WB stages, plus a multi-cycle (MUL/DIV) unit result. It raises the ID stall for load-use, RAW/WAW hazards against the outstanding multi-cycle op, and multi-cycle structural hazards. A one-entry pending-write scoreboard FSM and a saturating stall-cycle counter are kept internally.

## Interface
- NUM_RD, 2, number of ID register read ports (1..4)
- AW, 5, register address width; address 0 is the hardwired zero register
- CW, 32, stall-counter width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rd_en  in  NUM_RD  port i reads a register (bit i)
- rd_addr  in  NUM_RD*AW  port i address in bits [i*AW +: AW]
- id_wen, id_waddr  in  1, AW  ID instruction writes a register / destination
- exe_wen, exe_waddr, exe_is_load  in  1, AW, 1  EXE-stage write info; load flag
- mem_wen, mem_waddr, mem_is_load  in  1, AW, 1  MEM-stage write info; load flag
- wb_wen, wb_waddr  in  1, AW  WB-stage write info
- md_start  in  1  ID instruction is a MUL/DIV writing id_waddr (id_wen=1)
- md_done  in  1  one-cycle pulse: multi-cycle result valid and written to the regfile this cycle
- flush  in  1  pipeline flush; aborts any outstanding multi-cycle op
- fwd_sel  out  NUM_RD*3  port i select [i*3 +: 3]: 0 regfile, 1 EXE, 2 MEM, 3 WB, 4 MD result
- stall  out  1  hold PC and IF/ID, insert bubble into ID/EXE
- pc_write, ir_write  out  1  both equal ~stall
- md_busy  out  1  multi-cycle op outstanding
- stall_cnt  out  CW  saturating count of stalled cycles

## Operation
- Port hit (stage S, port i): rd_en[i] & S_wen & (rd_addr_i != 0) & (rd_addr_i == S_waddr).
- Forward priority per port: EXE > MEM > WB > MD (MD hit = busy & md_done & addr == pend_addr) > regfile.
- Load-use stall: any port EXE-hit with exe_is_load, or any port MEM-hit with mem_is_load and no EXE hit on that port.
- MD RAW stall: busy & ~md_done & any port addr == pend_addr (nonzero, rd_en set).
- MD WAW stall: busy & ~md_done & id_wen & id_waddr == pend_addr, id_waddr != 0.
- Structural stall: md_start & busy & ~md_done.
- stall = OR of the above, forced 0 when flush=1 or rst=1.
- FSM IDLE/BUSY, with pend_addr register:
  - IDLE -> BUSY on md_start & ~stall. pend_addr <= id_waddr.
  - BUSY & md_done & md_start & ~stall: stays BUSY, pend_addr <= id_waddr.
  - BUSY & md_done without accepted start: -> IDLE.
  - flush in any state: -> IDLE. A md_start in the flush cycle is ignored.
  - md_done while IDLE is ignored.
- md_busy = (state == BUSY).
- stall_cnt increments each cycle stall=1 and saturates at 2^CW-1. It is cleared only by rst.

## Timing
- Reset (synchronous): state IDLE, pend_addr 0, stall_cnt 0, md_busy 0. During rst, stall=0 and pc_write=ir_write=1.
- fwd_sel, stall, pc_write, ir_write are combinational, valid in the same cycle as the inputs. There is no registered latency.
- Load in EXE: 1 stall cycle. The next cycle the load is in MEM and still stalls. The cycle after that, WB forwarding gives fwd_sel=3 with no stall.
- md_busy rises the cycle after an accepted md_start and falls the cycle after md_done.
- In the md_done cycle, a dependent reader gets fwd_sel=4 and does not stall.
- stall_cnt reflects a stall cycle on the following edge.

## Test plan
- Reset: hold rst 2 cycles with all requests active -> stall=0, md_busy=0, stall_cnt=0 after release.
- ALU chain: exe writes r5 (non-load), port0 reads r5 -> fwd_sel[2:0]=1, stall=0. mem and wb both write r5 with no EXE hit -> fwd_sel=2 (MEM over WB).
- Load-use: exe_is_load r7, port1 reads r7 -> stall=1 for 2 cycles (EXE, then MEM), then fwd_sel[5:3]=3. stall_cnt goes from 0 to 2.
- Zero register and disabled port: exe writes r0 and port reads r0 -> fwd_sel=0, stall=0. rd_en=0 on a matching address -> fwd_sel=0.
- Multi-cycle: md_start r9, then reader of r9 -> stalls while BUSY. On the md_done cycle, fwd_sel=4 and stall=0. Next cycle md_busy=0. A second md_start during BUSY stalls until md_done; back-to-back start accepted in the md_done cycle keeps md_busy=1 with pend_addr updated.
- Flush mid-op: BUSY on r9, assert flush -> stall=0 that cycle, md_busy=0 next cycle, later r9 reader does not stall.
